// File: rtl/display_scan_ctrl_if.sv
// Display scan bus: value/decimal-point/blanking inputs toward the scanner and
// the digit select, enable and segment data it drives back out.
interface display_scan_ctrl_if;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned NIB_W   = 4;

    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] dp_in;
    logic              lz_blank;
    logic [SEL_W-1:0]  sel;
    logic              sel_en;
    logic [NIB_W-1:0]  nibble;
    logic              dp;
    logic              frame_tick;

    modport master (
        output data, dp_in, lz_blank,
        input  sel, sel_en, nibble, dp, frame_tick
    );

    modport slave (
        input  data, dp_in, lz_blank,
        output sel, sel_en, nibble, dp, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with per-slot blanking,
// per-frame snapshot of the display value and leading-zero suppression.
module display_scan_ctrl #(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned NIB_W  = 4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW0 = CNT_W'(BLANK_CYC);

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_SHOW  = 2'd1,
        PH_GUARD = 2'd2
    } phase_t;

    phase_t              phase_q, phase_nx;
    logic                run_q;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic [SEL_W-1:0]    sel_q, sel_nx;
    logic [DATA_W-1:0]   snap_q, snap_nx;
    logic [DIGITS-1:0]   dps_q, dps_nx;
    logic                lz_q, lz_nx;
    logic                sel_en_q, sel_en_nx;
    logic [NIB_W-1:0]    nibble_q, nibble_nx;
    logic                dp_q, dp_nx;
    logic                tick_q, tick_nx;
    logic                wrap, snap_cyc, upper_zero, suppress;

    // Next-state and next-output computation; outputs are registered from the
    // next cnt/sel so they always match the counters in the same cycle.
    always_comb begin
        phase_nx   = phase_q;
        cnt_nx     = cnt_q;
        sel_nx     = sel_q;
        snap_nx    = snap_q;
        dps_nx     = dps_q;
        lz_nx      = lz_q;
        wrap       = 1'b0;
        snap_cyc   = 1'b0;
        upper_zero = 1'b0;
        suppress   = 1'b0;
        nibble_nx  = '0;

        // First cycle after reset release is a priming cycle; the digit-0
        // slot with its FRAME_TICK and snapshot follows it.
        if (run_q) begin
            wrap   = (cnt_q == CNT_LAST);
            cnt_nx = wrap ? '0 : cnt_q + CNT_W'(1);
            sel_nx = wrap ? sel_q + SEL_W'(1) : sel_q;
        end

        snap_cyc = run_q && (cnt_q == '0) && (sel_q == '0);
        if (snap_cyc) begin
            snap_nx = bus.data;
            dps_nx  = bus.dp_in;
        end
        if (run_q && (cnt_q == '0)) begin
            lz_nx = bus.lz_blank;
        end

        case (phase_q)
            PH_BLANK: if (run_q && (cnt_nx == CNT_SHOW0)) phase_nx = PH_SHOW;
            PH_SHOW:  if (cnt_nx == CNT_LAST)             phase_nx = PH_GUARD;
            PH_GUARD: phase_nx = PH_BLANK;
            default:  phase_nx = PH_BLANK;
        endcase

        case (sel_nx)
            2'd0: begin
                nibble_nx  = snap_nx[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nibble_nx  = snap_nx[7:4];
                upper_zero = (snap_nx[15:4] == '0);
            end
            2'd2: begin
                nibble_nx  = snap_nx[11:8];
                upper_zero = (snap_nx[15:8] == '0);
            end
            default: begin
                nibble_nx  = snap_nx[15:12];
                upper_zero = (snap_nx[15:12] == '0);
            end
        endcase

        // Digit 0 never suppressed: upper_zero is forced low for it above.
        suppress  = lz_nx && upper_zero && !dps_nx[sel_nx];
        sel_en_nx = (phase_nx == PH_SHOW) && !suppress;
        dp_nx     = dps_nx[sel_nx];
        tick_nx   = (cnt_nx == '0) && (sel_nx == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_BLANK;
            run_q    <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= '0;
            snap_q   <= '0;
            dps_q    <= '0;
            lz_q     <= 1'b0;
            sel_en_q <= 1'b0;
            nibble_q <= '0;
            dp_q     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            phase_q  <= phase_nx;
            run_q    <= 1'b1;
            cnt_q    <= cnt_nx;
            sel_q    <= sel_nx;
            snap_q   <= snap_nx;
            dps_q    <= dps_nx;
            lz_q     <= lz_nx;
            sel_en_q <= sel_en_nx;
            nibble_q <= nibble_nx;
            dp_q     <= dp_nx;
            tick_q   <= tick_nx;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_en     = sel_en_q;
    assign bus.nibble     = nibble_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
module tb_display_scan_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (bus.frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.frame_tick), 32'd1);
    endtask

    // Checks one full frame starting at the FRAME_TICK cycle; optionally
    // changes the inputs at cycle index chg_i of the frame.
    task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] dps,
                               input logic lz, input int chg_i, input logic [15:0] nd,
                               input logic [3:0] ndp, input logic nlz);
        for (int i = 0; i < 32; i++) begin
            int   slot;
            int   c;
            logic supp;
            logic exp_en;
            slot   = i / 8;
            c      = i % 8;
            supp   = lz && (slot != 0) && ((val >> (4 * slot)) == 16'h0) && !dps[slot];
            exp_en = (c >= 2) && (c <= 6) && !supp;
            chk($sformatf("%s_i%0d_sel", tag, i), 32'(bus.sel), 32'(slot));
            chk($sformatf("%s_i%0d_en", tag, i), 32'(bus.sel_en), 32'(exp_en));
            chk($sformatf("%s_i%0d_tick", tag, i), 32'(bus.frame_tick), 32'(i == 0));
            if (i != 0) begin
                chk($sformatf("%s_i%0d_nib", tag, i), 32'(bus.nibble), 32'(val[4*slot +: 4]));
                chk($sformatf("%s_i%0d_dp", tag, i), 32'(bus.dp), 32'(dps[slot]));
            end
            if (i == chg_i) begin
                bus.data     = nd;
                bus.dp_in    = ndp;
                bus.lz_blank = nlz;
            end
            @(negedge clk);
        end
    endtask

    // SEL may only change with SEL_EN low in the cycles before and after.
    logic [1:0] prev_sel;
    logic       prev_en;
    logic       prev_valid;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && bus.sel !== prev_sel) begin
                chk("sel_change_en_before", 32'(prev_en), 32'd0);
                chk("sel_change_en_after", 32'(bus.sel_en), 32'd0);
            end
            prev_sel   = bus.sel;
            prev_en    = bus.sel_en;
            prev_valid = 1'b1;
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.data     = 16'h1234;
        bus.dp_in    = 4'h0;
        bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_en", 32'(bus.sel_en), 32'd0);
        chk("rst_nib", 32'(bus.nibble), 32'd0);
        chk("rst_dp", 32'(bus.dp), 32'd0);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);

        rst_n = 1'b1;
        wait_tick("first_tick");
        chk("first_tick_nib", 32'(bus.nibble), 32'd0);
        check_frame("f1", 16'h1234, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);
        check_frame("f2", 16'h1234, 4'h0, 1'b0, 11, 16'hABCD, 4'h0, 1'b0);
        check_frame("f3", 16'hABCD, 4'h0, 1'b0, 31, 16'h0007, 4'h0, 1'b1);
        check_frame("f4", 16'h0007, 4'h0, 1'b1, 31, 16'h0007, 4'b0100, 1'b1);
        check_frame("f5", 16'h0007, 4'b0100, 1'b1, 31, 16'h0000, 4'h0, 1'b1);
        check_frame("f6", 16'h0000, 4'h0, 1'b1, 31, 16'h1234, 4'h0, 1'b0);
        check_frame("f7", 16'h1234, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);

        // Abort mid-slot with the digit enabled.
        repeat (20) @(negedge clk);
        chk("pre_rst_sel", 32'(bus.sel), 32'd2);
        chk("pre_rst_en", 32'(bus.sel_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(bus.sel), 32'd0);
        chk("async_rst_en", 32'(bus.sel_en), 32'd0);
        chk("async_rst_nib", 32'(bus.nibble), 32'd0);
        chk("async_rst_dp", 32'(bus.dp), 32'd0);
        chk("async_rst_tick", 32'(bus.frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_tick("restart_tick");
        chk("restart_tick_nib", 32'(bus.nibble), 32'd0);
        check_frame("f8", 16'h1234, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);
        check_frame("f9", 16'h1234, 4'h0, 1'b0, 31, 16'h5000, 4'h0, 1'b1);
        check_frame("f10", 16'h5000, 4'h0, 1'b1, -1, 16'h0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
